debounce_multi: RTL and testbench

//  N-channel debouncer for push-buttons/switches on the ov7670 capture boards.

---
 rtl/debounce_multi.sv | 157 +++++++++++++++
 tb/tb_debounce_multi.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// N-channel debouncer: 2-flop synchroniser, stability counter, debounced level, rise/fall pulses.
// Optional macro DEBOUNCE_AUTOREP_EN adds a per-channel hold/auto-repeat pulse on rep_p.
module debounce_multi #(
  parameter int N_CH     = 4,
  parameter int DEB_CYC  = 1_000_000,
  parameter int HOLD_CYC = 50_000_000,
  parameter int REP_CYC  = 20_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sig_in,
  output logic [N_CH-1:0] sig_out,
  output logic [N_CH-1:0] rise_p,
  output logic [N_CH-1:0] fall_p,
  output logic [N_CH-1:0] rep_p
);

  localparam int MAX_DH  = (DEB_CYC > HOLD_CYC) ? DEB_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_DH > REP_CYC) ? MAX_DH : REP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

  // Bit 1 of the encoding is the debounced level.
  typedef enum logic [1:0] {
    LOW      = 2'b00,
    LOW_CHK  = 2'b01,
    HIGH     = 2'b10,
    HIGH_CHK = 2'b11
  } state_t;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic             meta;
    logic             sync;
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             rise_nx;
    logic             fall_nx;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta   <= 1'b0;
        sync   <= 1'b0;
        state  <= LOW;
        cnt    <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        meta   <= sig_in[g];
        sync   <= meta;
        state  <= state_nx;
        cnt    <= cnt_nx;
        rise_q <= rise_nx;
        fall_q <= fall_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rise_nx  = 1'b0;
      fall_nx  = 1'b0;
      case (state)
        LOW: begin
          if (sync) begin
            state_nx = LOW_CHK;
            cnt_nx   = CNT_ONE;
          end
        end
        LOW_CHK: begin
          if (!sync) begin
            state_nx = LOW;
            cnt_nx   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nx = HIGH;
            cnt_nx   = '0;
            rise_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!sync) begin
            state_nx = HIGH_CHK;
            cnt_nx   = CNT_ONE;
          end
        end
        HIGH_CHK: begin
          if (sync) begin
            state_nx = HIGH;
            cnt_nx   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nx = LOW;
            cnt_nx   = '0;
            fall_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
      endcase
    end

    assign sig_out[g] = state[1];
    assign rise_p[g]  = rise_q;
    assign fall_p[g]  = fall_q;

`ifdef DEBOUNCE_AUTOREP_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hcnt_nx;
    logic             rep_phase;
    logic             rep_phase_nx;
    logic             rep_nx;
    logic             rep_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hcnt      <= '0;
        rep_phase <= 1'b0;
        rep_q     <= 1'b0;
      end else begin
        hcnt      <= hcnt_nx;
        rep_phase <= rep_phase_nx;
        rep_q     <= rep_nx;
      end
    end

    // Counts only while the level stays high across the edge, so entry (rise) and exit (fall) never repeat.
    always_comb begin
      hcnt_nx      = '0;
      rep_phase_nx = 1'b0;
      rep_nx       = 1'b0;
      if (state[1] && state_nx[1]) begin
        hcnt_nx      = hcnt + CNT_ONE;
        rep_phase_nx = rep_phase;
        if (hcnt == (rep_phase ? REP_LAST : HOLD_LAST)) begin
          rep_nx       = 1'b1;
          hcnt_nx      = '0;
          rep_phase_nx = 1'b1;
        end
      end
    end

    assign rep_p[g] = rep_q;
`else
    assign rep_p[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed corner cases, a settling table, and
// randomized stimulus compared every cycle against a sample-window reference model.
module tb_debounce_multi;

  localparam int N    = 4;
  localparam int DEB  = 8;
  localparam int HOLD = 40;
  localparam int REP  = 10;

  logic         clk = 1'b1;
  logic         rst = 1'b0;
  logic [N-1:0] sig_in;
  logic [N-1:0] sig_out;
  logic [N-1:0] rise_p;
  logic [N-1:0] fall_p;
  logic [N-1:0] rep_p;

  always #5 clk = ~clk;

  debounce_multi #(
    .N_CH    (N),
    .DEB_CYC (DEB),
    .HOLD_CYC(HOLD),
    .REP_CYC (REP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .sig_out(sig_out),
    .rise_p (rise_p),
    .fall_p (fall_p),
    .rep_p  (rep_p)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a level flips when the last DEB synchronised samples all disagree with it.
  // Synchronised sample at edge n is the raw input taken at edge n-2 (zero before that).
  logic [N-1:0] raw_h[$];
  logic [N-1:0] sync_h[$];
  logic [N-1:0] m_lvl  = '0;
  logic [N-1:0] m_rise = '0;
  logic [N-1:0] m_fall = '0;
  logic [N-1:0] m_rep  = '0;
  int           m_rise_edge[N];
  int           cyc = 0;

  always @(posedge clk or posedge rst) begin
    logic [N-1:0] s;
    bit           flip;
    int           age;
    if (rst) begin
      raw_h.delete();
      sync_h.delete();
      m_lvl  = '0;
      m_rise = '0;
      m_fall = '0;
      m_rep  = '0;
      cyc    = 0;
    end else begin
      cyc++;
      s = (raw_h.size() >= 2) ? raw_h[raw_h.size()-2] : '0;
      raw_h.push_back(sig_in);
      if (raw_h.size() > 2) void'(raw_h.pop_front());
      sync_h.push_back(s);
      if (sync_h.size() > DEB) void'(sync_h.pop_front());
      m_rise = '0;
      m_fall = '0;
      m_rep  = '0;
      for (int c = 0; c < N; c++) begin
        flip = (sync_h.size() == DEB);
        for (int k = 0; k < DEB; k++)
          if (sync_h[k][c] == m_lvl[c]) flip = 1'b0;
`ifdef DEBOUNCE_AUTOREP_EN
        if (m_lvl[c] && !flip) begin
          age = cyc - m_rise_edge[c];
          if (age >= HOLD && ((age - HOLD) % REP) == 0) m_rep[c] = 1'b1;
        end
`endif
        if (flip) begin
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) begin
            m_rise[c]      = 1'b1;
            m_rise_edge[c] = cyc;
          end else begin
            m_fall[c] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check($sformatf("scoreboard@%0d", cyc),
          32'({sig_out, rise_p, fall_p, rep_p}),
          32'({m_lvl, m_rise, m_fall, m_rep}));
  end

  int w_rise, w_fall, w_rep, w_high, w_first_rise, w_first_fall, w_first_rep;

  task automatic watch_reset();
    w_rise = 0; w_fall = 0; w_rep = 0; w_high = 0;
    w_first_rise = -1; w_first_fall = -1; w_first_rep = -1;
  endtask

  task automatic watch(input int n, input int ch);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rise_p[ch]) begin w_rise++; if (w_first_rise < 0) w_first_rise = cyc; end
      if (fall_p[ch]) begin w_fall++; if (w_first_fall < 0) w_first_fall = cyc; end
      if (rep_p[ch])  begin w_rep++;  if (w_first_rep  < 0) w_first_rep  = cyc; end
      if (sig_out[ch]) w_high++;
    end
  endtask

  typedef struct {
    logic [N-1:0] in;
    int           hold;
    logic [N-1:0] exp_out;
  } vec_t;

  vec_t tv[8];

  initial begin
    int          c0;
    logic [5:0]  gl;

    tv[0] = '{4'hF, 12, 4'hF};
    tv[1] = '{4'h0, 12, 4'h0};
    tv[2] = '{4'h5, 12, 4'h5};
    tv[3] = '{4'hA,  7, 4'h5};
    tv[4] = '{4'hA,  5, 4'hA};
    tv[5] = '{4'h3,  9, 4'hA};
    tv[6] = '{4'h3,  1, 4'h3};
    tv[7] = '{4'h0, 12, 4'h0};

    // Reset with all inputs high
    sig_in = '1;
    #1 rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("reset_outs", 32'({sig_out, rise_p, fall_p, rep_p}), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (9) begin
      @(negedge clk);
      check("rise_before_edge10", 32'(rise_p), 0);
    end
    @(negedge clk);
    check("rise_edge10", 32'(rise_p), 32'hF);
    check("level_edge10", 32'(sig_out), 32'hF);

    // Glitch rejection on ch0
    sig_in = '0;
    repeat (12) @(negedge clk);
    check("all_low", 32'(sig_out), 0);
    gl = 6'b101001;
    for (int i = 0; i < 6; i++) begin
      sig_in[0] = gl[i];
      c0 = cyc;
      if (i < 5) @(negedge clk);
    end
    watch_reset();
    watch(30, 0);
    check("glitch_rise_count", 32'(w_rise), 1);
    check("glitch_rise_edge", 32'(w_first_rise), 32'(c0 + DEB + 2));

    // Short pulse on ch1: 7 cycles rejected, 8 cycles accepted
    sig_in[1] = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    sig_in[1] = 1'b0;
    watch_reset();
    watch(25, 1);
    check("short7_pulses", 32'(w_rise + w_fall), 0);
    check("short7_level", 32'(w_high), 0);
    sig_in[1] = 1'b1;
    c0 = cyc;
    repeat (DEB) @(negedge clk);
    sig_in[1] = 1'b0;
    watch_reset();
    watch(30, 1);
    check("pulse8_rise_count", 32'(w_rise), 1);
    check("pulse8_fall_count", 32'(w_fall), 1);
    check("pulse8_rise_edge", 32'(w_first_rise), 32'(c0 + DEB + 2));
    check("pulse8_fall_gap", 32'(w_first_fall - w_first_rise), 32'(DEB));

    // Simultaneous rise on ch2 and fall on ch3
    sig_in[3] = 1'b1;
    repeat (12) @(negedge clk);
    sig_in[2] = 1'b1;
    sig_in[3] = 1'b0;
    repeat (DEB + 1) begin
      @(negedge clk);
      check("simul_early", 32'(rise_p | fall_p), 0);
    end
    @(negedge clk);
    check("simul_rise", 32'(rise_p), 32'h4);
    check("simul_fall", 32'(fall_p), 32'h8);
    check("simul_level", 32'(sig_out), 32'h5);

    // Reset in the middle of a count
    sig_in = '0;
    repeat (12) @(negedge clk);
    sig_in[0] = 1'b1;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_outs", 32'({sig_out, rise_p, fall_p, rep_p}), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    watch_reset();
    watch(20, 0);
    check("rst_mid_rise_count", 32'(w_rise), 1);
    check("rst_mid_rise_edge", 32'(w_first_rise), 32'(DEB + 2));

    // Held high for 100 cycles on ch0
    sig_in = '0;
    repeat (12) @(negedge clk);
    sig_in[0] = 1'b1;
    c0 = cyc;
    watch_reset();
    watch(100, 0);
    sig_in[0] = 1'b0;
    watch(30, 0);
    check("hold_rise_count", 32'(w_rise), 1);
    check("hold_fall_count", 32'(w_fall), 1);
`ifdef DEBOUNCE_AUTOREP_EN
    check("hold_rep_count", 32'(w_rep), 6);
    check("hold_first_rep", 32'(w_first_rep), 32'(c0 + DEB + 2 + HOLD));
`else
    check("hold_rep_count", 32'(w_rep), 0);
`endif

    // Settling table
    for (int i = 0; i < 8; i++) begin
      sig_in = tv[i].in;
      repeat (tv[i].hold) @(negedge clk);
      check($sformatf("table[%0d]", i), 32'(sig_out), 32'(tv[i].exp_out));
    end

    // Random stimulus, checked by the scoreboard
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) sig_in = N'($urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
